picosoc_gpio: RTL and testbench

PICOSOC_GPIO -- requirements
Module: picosoc_gpio

---
 rtl/picosoc_gpio_if.sv | 27 ++
 rtl/picosoc_gpio.sv | 137 +++++++++++++
 tb/tb_picosoc_gpio.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/picosoc_gpio_if.sv
// Native PicoRV32 iomem bus bundle used between the SoC fabric and the GPIO block.
interface picosoc_gpio_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_ready,
        input  iomem_rdata
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_ready,
        output iomem_rdata
    );
endinterface

// File: rtl/picosoc_gpio.sv
// Memory-mapped GPIO for PicoSoC: output/enable registers, atomic set/clear/toggle,
// synchronised inputs and edge-triggered sticky interrupt status.
module picosoc_gpio #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    picosoc_gpio_if.slave     bus,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    localparam logic [5:0] OffOut    = 6'h00;
    localparam logic [5:0] OffOe     = 6'h01;
    localparam logic [5:0] OffIn     = 6'h02;
    localparam logic [5:0] OffSet    = 6'h03;
    localparam logic [5:0] OffClr    = 6'h04;
    localparam logic [5:0] OffTgl    = 6'h05;
    localparam logic [5:0] OffRise   = 6'h06;
    localparam logic [5:0] OffFall   = 6'h07;
    localparam logic [5:0] OffStatus = 6'h08;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             sel;
    logic             is_wr;
    logic [5:0]       reg_off;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] events;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_val;
    logic             unused_bus;

    // ready_q blocks re-selection so a held valid yields exactly one pulse.
    assign sel     = bus.iomem_valid & ~ready_q & (bus.iomem_addr[31:24] == BASE_ADDR);
    assign is_wr   = |bus.iomem_wstrb;
    assign reg_off = bus.iomem_addr[7:2];

    assign lane_mask = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                        {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
    assign wmask     = lane_mask[WIDTH-1:0];
    assign wd        = bus.iomem_wdata[WIDTH-1:0] & wmask;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign events    = (sync_last & ~prev_q & rise_en_q) | (~sync_last & prev_q & fall_en_q);

    assign unused_bus = ^{bus.iomem_addr, bus.iomem_wdata, lane_mask};

    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (sel && is_wr) begin
            case (reg_off)
                OffOut:    out_d     = (out_q & ~wmask) | wd;
                OffOe:     oe_d      = (oe_q & ~wmask) | wd;
                OffSet:    out_d     = out_q | wd;
                OffClr:    out_d     = out_q & ~wd;
                OffTgl:    out_d     = out_q ^ wd;
                OffRise:   rise_en_d = (rise_en_q & ~wmask) | wd;
                OffFall:   fall_en_d = (fall_en_q & ~wmask) | wd;
                OffStatus: clr       = wd;
                default:   ;
            endcase
        end
        // New events override a coincident W1C.
        status_d = (status_q & ~clr) | events;
    end

    always_comb begin
        rd_val = '0;
        case (reg_off)
            OffOut:    rd_val[WIDTH-1:0] = out_q;
            OffOe:     rd_val[WIDTH-1:0] = oe_q;
            OffIn:     rd_val[WIDTH-1:0] = sync_last;
            OffRise:   rd_val[WIDTH-1:0] = rise_en_q;
            OffFall:   rd_val[WIDTH-1:0] = fall_en_q;
            OffStatus: rd_val[WIDTH-1:0] = status_q;
            default:   ;
        endcase
        ready_d = sel;
        rdata_d = (sel && !is_wr) ? rd_val : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= sync_last;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign gpio_out        = out_q;
    assign gpio_oe         = oe_q;
    assign irq             = |status_q;

endmodule

// File: tb/tb_picosoc_gpio.sv
// Drives an 8-bit and a 12-bit GPIO instance with identical bus traffic and checks both
// against a transaction-level register model.
module tb_picosoc_gpio;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        valid;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [7:0]  gin8, gout8, goe8;
    logic [11:0] gin12, gout12, goe12;
    logic        irq8, irq12;

    picosoc_gpio_if bus8 ();
    picosoc_gpio_if bus12 ();

    assign bus8.iomem_valid  = valid;
    assign bus8.iomem_wstrb  = wstrb;
    assign bus8.iomem_addr   = addr;
    assign bus8.iomem_wdata  = wdata;
    assign bus12.iomem_valid = valid;
    assign bus12.iomem_wstrb = wstrb;
    assign bus12.iomem_addr  = addr;
    assign bus12.iomem_wdata = wdata;

    picosoc_gpio #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus8),
        .gpio_in  (gin8),
        .gpio_out (gout8),
        .gpio_oe  (goe8),
        .irq      (irq8)
    );

    picosoc_gpio #(.WIDTH(12)) dut12 (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus12),
        .gpio_in  (gin12),
        .gpio_out (gout12),
        .gpio_oe  (goe12),
        .irq      (irq12)
    );

    int nerr = 0;
    int nchk = 0;

    logic [31:0] m_out  [2];
    logic [31:0] m_oe   [2];
    logic [31:0] m_rise [2];
    logic [31:0] m_fall [2];
    logic [31:0] m_stat [2];
    logic [31:0] m_rd   [2];
    bit          m_ready[2];
    logic [31:0] m_hist [2][3];  // [0] newest pin sample; in = [1], prev = [2]
    logic [31:0] last_rd8, last_rd12;

    function automatic logic [31:0] wm(input int k);
        return (k == 0) ? 32'h0000_00FF : 32'h0000_0FFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("ready8", {31'b0, bus8.iomem_ready}, {31'b0, m_ready[0]});
        if (m_ready[0]) chk("rdata8", bus8.iomem_rdata, m_rd[0]);
        chk("out8", {24'b0, gout8}, m_out[0]);
        chk("oe8", {24'b0, goe8}, m_oe[0]);
        chk("irq8", {31'b0, irq8}, {31'b0, |m_stat[0]});
        chk("ready12", {31'b0, bus12.iomem_ready}, {31'b0, m_ready[1]});
        if (m_ready[1]) chk("rdata12", bus12.iomem_rdata, m_rd[1]);
        chk("out12", {20'b0, gout12}, m_out[1]);
        chk("oe12", {20'b0, goe12}, m_oe[1]);
        chk("irq12", {31'b0, irq12}, {31'b0, |m_stat[1]});
    endtask

    // Advance the model by one clock edge using the currently driven inputs, then step the DUTs.
    task automatic tick();
        logic [31:0] gv, bm, d, sy, pv, ev, clr, rv;
        bit          sel;
        for (int k = 0; k < 2; k++) begin
            gv = (k == 0) ? {24'b0, gin8} : {20'b0, gin12};
            if (!resetn) begin
                m_out[k] = 0; m_oe[k] = 0; m_rise[k] = 0; m_fall[k] = 0; m_stat[k] = 0;
                m_rd[k] = 0; m_ready[k] = 0;
                for (int j = 0; j < 3; j++) m_hist[k][j] = 0;
            end else begin
                sy  = m_hist[k][1];
                pv  = m_hist[k][2];
                ev  = ((sy & ~pv & m_rise[k]) | (~sy & pv & m_fall[k])) & wm(k);
                sel = valid && !m_ready[k] && (addr[31:24] == 8'h03);
                bm  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}} & wm(k);
                d   = wdata & bm;
                clr = 0;
                rv  = 0;
                if (sel && wstrb != 4'h0) begin
                    case (addr[7:2])
                        6'd0: m_out[k]  = (m_out[k] & ~bm) | d;
                        6'd1: m_oe[k]   = (m_oe[k] & ~bm) | d;
                        6'd3: m_out[k]  = m_out[k] | d;
                        6'd4: m_out[k]  = m_out[k] & ~d;
                        6'd5: m_out[k]  = m_out[k] ^ d;
                        6'd6: m_rise[k] = (m_rise[k] & ~bm) | d;
                        6'd7: m_fall[k] = (m_fall[k] & ~bm) | d;
                        6'd8: clr = d;
                        default: ;
                    endcase
                end else if (sel) begin
                    case (addr[7:2])
                        6'd0: rv = m_out[k];
                        6'd1: rv = m_oe[k];
                        6'd2: rv = sy;
                        6'd6: rv = m_rise[k];
                        6'd7: rv = m_fall[k];
                        6'd8: rv = m_stat[k];
                        default: rv = 0;
                    endcase
                end
                m_stat[k]    = (m_stat[k] & ~clr) | ev;
                m_ready[k]   = sel;
                m_rd[k]      = sel ? rv : 0;
                m_hist[k][2] = m_hist[k][1];
                m_hist[k][1] = m_hist[k][0];
                m_hist[k][0] = gv;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // One bus transaction; valid is held across the second edge to prove a single pulse.
    task automatic access(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1;
        wstrb = s;
        addr  = a;
        wdata = d;
        tick();
        last_rd8  = bus8.iomem_rdata;
        last_rd12 = bus12.iomem_rdata;
        tick();
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    initial begin
        logic [5:0]  off;
        logic [7:0]  top;
        logic [3:0]  s;
        int          r;

        resetn = 1'b0; valid = 1'b0; wstrb = 4'h0; addr = 0; wdata = 0;
        gin8 = 0; gin12 = 0;
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0; m_oe[k] = 0; m_rise[k] = 0; m_fall[k] = 0; m_stat[k] = 0;
            m_rd[k] = 0; m_ready[k] = 0;
            for (int j = 0; j < 3; j++) m_hist[k][j] = 0;
        end
        tick();
        tick();
        chk("rst_out8", {24'b0, gout8}, 32'h0);
        chk("rst_irq8", {31'b0, irq8}, 32'h0);
        resetn = 1'b1;
        tick();

        // Plain write then read of OUT.
        access(4'hF, 32'h0300_0000, 32'h0000_00A5);
        chk("wr_out", {24'b0, gout8}, 32'hA5);
        access(4'h0, 32'h0300_0000, 32'h0);
        chk("rd_out", last_rd8, 32'h0000_00A5);

        // Atomic set / clear / toggle.
        access(4'hF, 32'h0300_0000, 32'h0000_00F0);
        access(4'hF, 32'h0300_000C, 32'h0000_000F);
        chk("set", {24'b0, gout8}, 32'hFF);
        access(4'hF, 32'h0300_0010, 32'h0000_0030);
        chk("clr", {24'b0, gout8}, 32'hCF);
        access(4'hF, 32'h0300_0014, 32'h0000_0081);
        chk("tgl", {24'b0, gout8}, 32'h4E);

        // Rising edge on bit0 reaches STATUS on the third edge.
        access(4'hF, 32'h0300_0018, 32'h1);
        gin8[0] = 1'b1; gin12[0] = 1'b1;
        tick();
        chk("rise_e1", {31'b0, irq8}, 32'h0);
        tick();
        chk("rise_e2", {31'b0, irq8}, 32'h0);
        tick();
        chk("rise_e3", {31'b0, irq8}, 32'h1);
        access(4'h0, 32'h0300_0020, 32'h0);
        chk("rd_status", last_rd8, 32'h1);
        access(4'hF, 32'h0300_0020, 32'h1);
        chk("w1c_irq", {31'b0, irq8}, 32'h0);

        // Falling edge on bit1 coincident with a W1C of the same bit: set wins.
        access(4'hF, 32'h0300_001C, 32'h2);
        gin8[1] = 1'b1; gin12[1] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        gin8[1] = 1'b0; gin12[1] = 1'b0;
        tick();
        tick();
        access(4'hF, 32'h0300_0020, 32'h2);
        chk("set_wins_irq", {31'b0, irq8}, 32'h1);
        access(4'h0, 32'h0300_0020, 32'h0);
        chk("set_wins_rd", last_rd8, 32'h2);
        access(4'hF, 32'h0300_0020, 32'hFFFF_FFFF);

        // Single byte lane into a 12-bit OE.
        access(4'h2, 32'h0300_0004, 32'h0000_FF00);
        chk("oe12_lane", {20'b0, goe12}, 32'hF00);
        chk("oe8_lane", {24'b0, goe8}, 32'h0);
        access(4'h0, 32'h0300_0004, 32'h0);
        chk("rd_oe12", last_rd12, 32'h0000_0F00);

        // Foreign base address is never acknowledged.
        access(4'hF, 32'h0500_0000, 32'h12);
        chk("foreign", {24'b0, gout8}, 32'h4E);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                gin8  = 8'($urandom);
                gin12 = 12'($urandom);
                tick();
            end else if (r == 2) begin
                tick();
            end else begin
                r   = $urandom_range(0, 11);
                off = (r > 8) ? 6'($urandom_range(9, 63)) : 6'(r);
                top = ($urandom_range(0, 7) == 0) ? 8'h05 : 8'h03;
                s   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                access(s, {top, 16'($urandom), off, 2'($urandom)}, $urandom);
            end
        end

        // Reset asserted while a write is presented; serviced afresh after release.
        valid = 1'b1; wstrb = 4'hF; addr = 32'h0300_0000; wdata = 32'h3C;
        resetn = 1'b0;
        tick();
        chk("rst_mid_ready", {31'b0, bus8.iomem_ready}, 32'h0);
        chk("rst_mid_out", {24'b0, gout8}, 32'h0);
        chk("rst_mid_irq", {31'b0, irq8}, 32'h0);
        resetn = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, bus8.iomem_ready}, 32'h1);
        chk("post_rst_out", {24'b0, gout8}, 32'h3C);
        tick();
        valid = 1'b0; wstrb = 4'h0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
